nubus_arb_ctrl: RTL and testbench
=================================

// Module: nubus_arb_ctrl
// PURPOSE
//  Sequences NuBus bus acquisition for the local master. Drives /RQST and the arbitration-cycle
//  enable into the combinational ARB<3:0> resolver, and times the 2-clock settle window.
//  Samples the resolver's grant and enforces NuBus fairness. Hands bus ownership to the master
//  controller (mst_gnt), holds it through locked sequences and releases it on completion.
// PARAMETERS
//  ARB_CYCLES  2  clocks arbcyn held low before arb_grant is sampled (>=2; 4-bit counter)
//  FAIR_EN     1  1 = defer new request while any other card holds /RQST (NuBus fairness)
// PORTS
//  nub_clkn     in   1  NuBus clock; all logic on rising edge
//  nub_reset    in   1  synchronous, active-high reset
//  mst_req      in   1  master wants the bus; level, held until mst_gnt
//  mst_lock     in   1  sampled with mst_done; 1 = keep ownership for the next transaction
//  mst_done     in   1  1-clock pulse: master's transaction finished (ACK seen)
//  mst_gnt      out  1  master owns bus and may drive START next clock
//  nub_rqstn    in   1  sampled bus /RQST (wired-OR, includes own drive)
//  nub_startn   in   1  sampled bus /START
//  nub_ackn     in   1  sampled bus /ACK
//  nub_rqst_oe  out  1  1 = drive /RQST low
//  arb_cyn      out  1  arbitration enable to resolver; 0 = compete on ARB<3:0>
//  arb_grant    in   1  resolver result; valid only after ARB_CYCLES clocks of arb_cyn=0
//  arb_busy     out  1  FSM not in IDLE (status)
// BEHAVIOUR
//  Reset: mst_gnt=0, nub_rqst_oe=0, arb_cyn=1, arb_busy=0; FSM=IDLE, cnt=0, bus_busy=0.
//  bus_busy tracker: set on a clock with nub_startn=0; cleared on a clock with nub_ackn=0 and
//   nub_startn=1. Simultaneous START and ACK (attention cycle): bus_busy unchanged.
//  States:
//   IDLE   mst_req=1: -> FAIR if FAIR_EN and nub_rqstn=0, else -> ARB (load cnt=ARB_CYCLES).
//   FAIR   wait for nub_rqstn=1 on one clock -> ARB; mst_req dropping -> IDLE.
//   ARB    nub_rqst_oe=1, arb_cyn=0. cnt decrements each clock. Another card's START
//          (nub_startn=0 while mst_gnt=0) reloads cnt, so a new round starts.
//          When cnt reaches 0:
//            arb_grant=1 -> WAITBUS.
//            arb_grant=0 -> stay in ARB and wait for the next START reload; never drop /RQST.
//   WAITBUS  nub_rqst_oe=1, arb_cyn=0.
//            arb_grant falls -> ARB with reload (a higher ID won a re-arbitration).
//            bus_busy=0 and nub_startn=1 -> OWN.
//   OWN    mst_gnt=1, nub_rqst_oe=0, arb_cyn=1 (the /RQST release and arb_cyn=1 take effect on
//          the same clock mst_gnt rises; fixed so that others see /RQST released in time).
//          mst_done with mst_lock=1 -> stay OWN.
//          mst_done with mst_lock=0 -> REL.
//   REL    mst_gnt=0 for one clock -> IDLE. No re-request is accepted in REL.
//  Latency: idle bus, FAIR satisfied, win -> mst_gnt rises ARB_CYCLES+2 clocks after mst_req.
//  mst_req dropped in ARB or WAITBUS: abort -> IDLE next clock; /RQST and arb_cyn are released.
//  mst_req dropped in OWN: ignored; release happens only via mst_done.
//  nub_reset mid-tenure: all outputs return to reset values on the next clock; no drain.
//  mst_done outside OWN is ignored. arb_grant is ignored whenever arb_cyn=1.
// STRUCTURE
//  Package nubus_pkg:
//   - arb_state_t enum: IDLE, FAIR, ARB, WAITBUS, OWN, REL.
//   - ARB_CNT_W=4 constant.
//  Sub-module nubus_tenure_mon: the bus_busy set/clear tracker, reused by the slave side.
//  The ARB<3:0> resolver is instantiated alongside this block at card top level, not inside it.
// TESTING
//  1 Idle bus, ID=0xF alone, ARB_CYCLES=2: mst_req at clk 0 -> arb_cyn=0 @1, mst_gnt=1 @4,
//    nub_rqst_oe=0 @4.
//  2 nub_rqstn=0 (other card) at req -> stays FAIR, nub_rqst_oe=0; rqstn=1 at clk 5
//    -> ARB @6.
//  3 Lose (arb_grant=0), other START at clk 7 -> cnt reloaded; grant=1 at next window
//    -> WAITBUS; bus_busy until ACK @12 -> mst_gnt @13.
//  4 OWN, mst_done+mst_lock=1 then mst_done+mst_lock=0 -> mst_gnt stays 1 across first,
//    0 one clock after second; REL then IDLE.
//  5 nub_reset asserted in WAITBUS and in OWN -> next clock mst_gnt=0, arb_cyn=1,
//    nub_rqst_oe=0, arb_busy=0.
//  6 mst_req dropped in ARB -> IDLE next clock, arb_cyn=1; START+ACK same clock
//    -> bus_busy unchanged.

Source files
------------

// File: rtl/nubus_pkg.sv
// Shared types and constants for the NuBus arbitration and tenure logic.
package nubus_pkg;

    localparam int ARB_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FAIR    = 3'd1,
        ARB     = 3'd2,
        WAITBUS = 3'd3,
        OWN     = 3'd4,
        REL     = 3'd5
    } arb_state_t;

endpackage

// File: rtl/nubus_tenure_mon.sv
// Tracks whether a bus transaction is in flight: set by /START, cleared by /ACK.
module nubus_tenure_mon (
    input  logic clk_i,
    input  logic rst_i,
    input  logic startn_i,
    input  logic ackn_i,
    output logic bus_busy_o
);

    logic bus_busy_q;
    logic bus_busy_d;

    // START and ACK together is an attention cycle, which leaves tenure untouched.
    always_comb begin
        bus_busy_d = bus_busy_q;
        if (!startn_i && ackn_i) begin
            bus_busy_d = 1'b1;
        end else if (startn_i && !ackn_i) begin
            bus_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_busy_q <= 1'b0;
        end else begin
            bus_busy_q <= bus_busy_d;
        end
    end

    assign bus_busy_o = bus_busy_q;

endmodule

// File: rtl/nubus_arb_ctrl.sv
// NuBus bus-acquisition sequencer: requests, arbitrates, hands ownership to the master.
// state   | meaning
// IDLE    | no request outstanding
// FAIR    | deferring while another card holds /RQST
// ARB     | driving /RQST, competing on ARB<3:0>, settle counter running
// WAITBUS | arbitration won, waiting for the current tenure to end
// OWN     | master owns the bus
// REL     | one-clock release before returning to IDLE
module nubus_arb_ctrl
    import nubus_pkg::*;
#(
    parameter int ARB_CYCLES = 2,
    parameter bit FAIR_EN    = 1'b1
) (
    input  logic nub_clkn,
    input  logic nub_reset,
    input  logic mst_req,
    input  logic mst_lock,
    input  logic mst_done,
    output logic mst_gnt,
    input  logic nub_rqstn,
    input  logic nub_startn,
    input  logic nub_ackn,
    output logic nub_rqst_oe,
    output logic arb_cyn,
    input  logic arb_grant,
    output logic arb_busy
);

    localparam logic [ARB_CNT_W-1:0] CNT_LOAD = ARB_CNT_W'(ARB_CYCLES);

    arb_state_t            state_q, state_d;
    logic [ARB_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  bus_busy;

    nubus_tenure_mon u_mon (
        .clk_i      (nub_clkn),
        .rst_i      (nub_reset),
        .startn_i   (nub_startn),
        .ackn_i     (nub_ackn),
        .bus_busy_o (bus_busy)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mst_req) begin
                    if (FAIR_EN && !nub_rqstn) begin
                        state_d = FAIR;
                    end else begin
                        state_d = ARB;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            FAIR: begin
                if (!mst_req) begin
                    state_d = IDLE;
                end else if (nub_rqstn) begin
                    state_d = ARB;
                    cnt_d   = CNT_LOAD;
                end
            end
            ARB: begin
                if (!mst_req) begin
                    state_d = IDLE;
                end else if (!nub_startn && !mst_gnt) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q != '0) begin
                    // Grant is sampled on the clock the counter reaches zero; a loss parks here.
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == ARB_CNT_W'(1) && arb_grant) begin
                        state_d = WAITBUS;
                    end
                end
            end
            WAITBUS: begin
                if (!mst_req) begin
                    state_d = IDLE;
                end else if (!arb_grant) begin
                    state_d = ARB;
                    cnt_d   = CNT_LOAD;
                end else if (!bus_busy && nub_startn) begin
                    state_d = OWN;
                end
            end
            OWN: begin
                if (mst_done && !mst_lock) begin
                    state_d = REL;
                end
            end
            REL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so /RQST drops on the same edge mst_gnt rises.
    always_ff @(posedge nub_clkn) begin
        if (nub_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mst_gnt     <= 1'b0;
            nub_rqst_oe <= 1'b0;
            arb_cyn     <= 1'b1;
            arb_busy    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mst_gnt     <= (state_d == OWN);
            nub_rqst_oe <= (state_d == ARB) || (state_d == WAITBUS);
            arb_cyn     <= !((state_d == ARB) || (state_d == WAITBUS));
            arb_busy    <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_nubus_arb_ctrl.sv
// Directed bench for nubus_arb_ctrl; outputs packed as {mst_gnt, nub_rqst_oe, arb_cyn, arb_busy}.
module tb_nubus_arb_ctrl;

    logic nub_clkn = 1'b0;
    logic nub_reset, mst_req, mst_lock, mst_done;
    logic nub_rqstn, nub_startn, nub_ackn, arb_grant;
    logic mst_gnt, nub_rqst_oe, arb_cyn, arb_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] O_IDLE = 4'b0010;
    localparam logic [3:0] O_ARB  = 4'b0101;
    localparam logic [3:0] O_HOLD = 4'b0011;
    localparam logic [3:0] O_OWN  = 4'b1011;

    always #5 nub_clkn = ~nub_clkn;

    nubus_arb_ctrl #(.ARB_CYCLES(2), .FAIR_EN(1'b1)) u_dut (
        .nub_clkn    (nub_clkn),
        .nub_reset   (nub_reset),
        .mst_req     (mst_req),
        .mst_lock    (mst_lock),
        .mst_done    (mst_done),
        .mst_gnt     (mst_gnt),
        .nub_rqstn   (nub_rqstn),
        .nub_startn  (nub_startn),
        .nub_ackn    (nub_ackn),
        .nub_rqst_oe (nub_rqst_oe),
        .arb_cyn     (arb_cyn),
        .arb_grant   (arb_grant),
        .arb_busy    (arb_busy)
    );

    task automatic tick();
        @(posedge nub_clkn);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {mst_gnt, nub_rqst_oe, arb_cyn, arb_busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_busy(input string tag, input logic exp);
        checks++;
        assert (u_dut.bus_busy === exp) else begin
            errors++;
            $error("FAIL %s: observed bus_busy %b expected %b", tag, u_dut.bus_busy, exp);
        end
    endtask

    initial begin
        nub_reset = 1'b1; mst_req = 1'b0; mst_lock = 1'b0; mst_done = 1'b0;
        nub_rqstn = 1'b1; nub_startn = 1'b1; nub_ackn = 1'b1; arb_grant = 1'b0;
        tick(); tick();
        check_out("reset_outs", O_IDLE);
        check_busy("reset_busy", 1'b0);
        nub_reset = 1'b0;

        // Idle bus, sole requester: gnt four clocks after request.
        arb_grant = 1'b1; mst_req = 1'b1;
        tick(); check_out("t1_arb_e1", O_ARB);
        tick(); check_out("t1_arb_e2", O_ARB);
        tick(); check_out("t1_wait_e3", O_ARB);
        tick(); check_out("t1_own_e4", O_OWN);
        mst_req = 1'b0;
        tick(); check_out("t1_req_drop_ignored", O_OWN);
        mst_done = 1'b1;
        tick(); check_out("t1_rel", O_HOLD);
        mst_done = 1'b0;
        tick(); check_out("t1_idle", O_IDLE);

        // Fairness deferral, then abort from ARB.
        nub_rqstn = 1'b0; mst_req = 1'b1;
        tick(); check_out("t2_fair", O_HOLD);
        tick(); check_out("t2_fair_hold", O_HOLD);
        nub_rqstn = 1'b1;
        tick(); check_out("t2_arb", O_ARB);
        mst_req = 1'b0;
        tick(); check_out("t6_abort_idle", O_IDLE);

        // Lose, reload on foreign START, win, wait out tenure.
        arb_grant = 1'b0; mst_req = 1'b1;
        tick(); tick(); tick();
        check_out("t3_lost_stay_arb", O_ARB);
        arb_grant = 1'b1;
        tick(); tick();
        check_out("t3_cnt0_ignores_grant", O_ARB);
        nub_startn = 1'b0;
        tick();
        nub_startn = 1'b1;
        check_busy("t3_start_sets_busy", 1'b1);
        tick(); tick();
        check_out("t3_waitbus", O_ARB);
        tick(); tick();
        check_out("t3_waitbus_busy", O_ARB);
        nub_startn = 1'b0; nub_ackn = 1'b0;
        tick();
        check_busy("t6_attn_busy_kept", 1'b1);
        check_out("t6_attn_no_own", O_ARB);
        nub_startn = 1'b1;
        tick();
        nub_ackn = 1'b1;
        check_busy("t3_ack_clears", 1'b0);
        check_out("t3_still_wait", O_ARB);
        tick(); check_out("t3_own", O_OWN);
        mst_req = 1'b0;

        // Locked sequence then release.
        mst_done = 1'b1; mst_lock = 1'b1;
        tick(); check_out("t4_locked_stay", O_OWN);
        mst_done = 1'b0; mst_lock = 1'b0;
        tick(); check_out("t4_own_hold", O_OWN);
        mst_done = 1'b1;
        tick(); check_out("t4_rel", O_HOLD);
        mst_done = 1'b0;
        tick(); check_out("t4_idle", O_IDLE);
        mst_done = 1'b1;
        tick(); check_out("done_in_idle_ignored", O_IDLE);
        mst_done = 1'b0;

        // Reset in WAITBUS and in OWN.
        mst_req = 1'b1;
        tick(); tick(); tick();
        nub_reset = 1'b1;
        tick(); check_out("t5_reset_waitbus", O_IDLE);
        nub_reset = 1'b0;
        tick(); tick(); tick(); tick();
        check_out("t5_own_again", O_OWN);
        nub_reset = 1'b1;
        tick(); check_out("t5_reset_own", O_IDLE);
        nub_reset = 1'b0; mst_req = 1'b0;
        tick();

        // Grant lost during WAITBUS forces a fresh arbitration round.
        nub_startn = 1'b0;
        tick();
        nub_startn = 1'b1;
        mst_req = 1'b1;
        tick(); tick(); tick();
        check_out("wb_busy_wait", O_ARB);
        arb_grant = 1'b0;
        tick();
        arb_grant = 1'b1; nub_ackn = 1'b0;
        tick();
        nub_ackn = 1'b1;
        check_busy("wb_ack_clears", 1'b0);
        tick(); check_out("wb_rearb_no_own", O_ARB);
        tick(); check_out("wb_own", O_OWN);
        mst_req = 1'b0; mst_done = 1'b1;
        tick(); check_out("wb_rel", O_HOLD);
        mst_done = 1'b0;
        tick(); check_out("wb_idle", O_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
